// File: rtl/gray_window_ctrl.sv
// gray_window_ctrl -- sliding-window controller for the grayscale conv input.
//
// Takes a raster pixel stream and builds one KSIZE x KSIZE window per valid
// output position. KSIZE-1 line RAMs (one write port, registered read,
// depth IMG_IN_WIDTH) hold the previous rows. Each accepted pixel reads its
// column from every line (stage 1). The next cycle writes the column back
// shifted down one line and pushes it into a KSIZE-column window register
// (stage 2). Windows go to a single output register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 arms a frame (IDLE only)
//   in_valid/in_ready     pixel handshake, in_data raster order
//   out_valid/out_ready   window handshake, out_win flattened window
//                         out_win[(i*KSIZE+j)*DW +: DW] = pixel(row-K+1+i, col-K+1+j)
//   busy                  frame in progress (ACTIVE or DRAIN)
//   frame_done            one-cycle pulse on handoff of the last window
//   err                   sticky protocol error
//
// Build option: define CNN_LB_ERR_FLAG_EN to enable the err detector.
// Without it, err is tied low.

`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif

// One line of history: single write port, registered read.
module gray_lb_line #(
  parameter int DEPTH = 28,
  parameter int DW    = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

module gray_window_ctrl #(
  parameter int IMG_IN_WIDTH  = 28,
  parameter int IMG_IN_HEIGHT = 28,
  parameter int KSIZE         = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [`CNN_DATA_IN_W-1:0]          in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [KSIZE*KSIZE*`CNN_DATA_IN_W-1:0] out_win,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               err
);
  localparam int DW = `CNN_DATA_IN_W;
  localparam int CW = (IMG_IN_WIDTH  > 1) ? $clog2(IMG_IN_WIDTH)  : 1;
  localparam int RW = (IMG_IN_HEIGHT > 1) ? $clog2(IMG_IN_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_IN_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(KSIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic stall, accept, s2_fire, load;

  // stage 1 registers: pixel and its position, RAM reads in flight
  logic          s1_vld;
  logic [DW-1:0] s1_pix;
  logic [CW-1:0] s1_col;
  logic [RW-1:0] s1_row;
  logic [DW-1:0] lb_rd [KSIZE-1];

  // window [i][j]: i=0 oldest row, j=0 leftmost column
  logic [KSIZE-1:0][KSIZE-1:0][DW-1:0] win_q, win_d, out_win_q;
  logic out_valid_q;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = (state_q == S_ACTIVE) && !stall;
  assign accept   = in_valid && in_ready;
  assign s2_fire  = s1_vld && !stall;
  // Columns 0..K-2 of each row and rows 0..K-2 only prime history.
  assign load     = s2_fire && (s1_row >= ROW_WIN0) && (s1_col >= COL_WIN0);

  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;

  // Line k holds row-1-k. Write-back moves each line's old value down one.
  // The write (previous column) and the read (current column) never share
  // an address because consecutive accepted pixels differ in column.
  for (genvar k = 0; k < KSIZE-1; k++) begin : g_line
    logic [DW-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = s1_pix;
    end else begin : g_tail
      assign wdata = lb_rd[k-1];
    end
    gray_lb_line #(.DEPTH(IMG_IN_WIDTH), .DW(DW), .AW(CW)) u_line (
      .clk     (clk),
      .wr_en   (s2_fire),
      .wr_addr (s1_col),
      .wr_data (wdata),
      .rd_en   (accept),
      .rd_addr (col_q),
      .rd_data (lb_rd[k])
    );
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && row_q == ROW_LAST && col_q == COL_LAST) state_d = S_DRAIN;
      S_DRAIN: begin
        // last pixel always yields a window, so this waits for its handoff
        if (!s1_vld && (!out_valid_q || out_ready)) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // raster position of the next pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pix <= '0;
      s1_col <= '0;
      s1_row <= '0;
    end else if (!stall) begin
      s1_vld <= accept;
      if (accept) begin
        s1_pix <= in_data;
        s1_col <= col_q;
        s1_row <= row_q;
      end
    end
  end

  // new column enters on the right: oldest line at top, live pixel at bottom
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE-1; j++)
        win_d[i][j] = win_q[i][j+1];
    for (int i = 0; i < KSIZE-1; i++)
      win_d[i][KSIZE-1] = lb_rd[KSIZE-2-i];
    win_d[KSIZE-1][KSIZE-1] = s1_pix;
  end

  // stage 2 window register and output slot; the output takes the freshly
  // shifted window so a pixel reaches out_valid two cycles after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      out_win_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (s2_fire) win_q <= win_d;
      if (load) begin
        out_win_q   <= win_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef CNN_LB_ERR_FLAG_EN
  logic err_q, err_set, err_clr;
  assign err_set = (in_valid && state_q != S_ACTIVE) || (start && state_q != S_IDLE);
  assign err_clr = start && state_q == S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (err_q && !err_clr) || err_set;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_window_ctrl.sv
// Directed bench for gray_window_ctrl: full frames with steady and random
// out_ready, a mid-frame start, a mid-frame reset and pixels offered in IDLE.

`ifndef CNN_DATA_IN_W
`define CNN_DATA_IN_W 8
`endif

module tb_gray_window_ctrl;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int K    = 3;
  localparam int DW   = `CNN_DATA_IN_W;
  localparam int WW   = K*K*DW;
  localparam int NPIX = W*H;
  localparam int NWIN = (H-K+1)*(W-K+1);
`ifdef CNN_LB_ERR_FLAG_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, busy, frame_done, err;
  logic [WW-1:0] out_win;

  always #5 clk = ~clk;

  gray_window_ctrl #(.IMG_IN_WIDTH(W), .IMG_IN_HEIGHT(H), .KSIZE(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_win    (out_win),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;
  bit acc = 1'b0;
  bit hold_prev = 1'b0;
  logic ov_prev = 1'b0;
  logic [WW-1:0] prev_win = '0;
  int exp_idx = 0, win_cnt = 0, done_cnt = 0;
  int cur_n = -1, acc_cyc = -1, ov_cyc = -1;

  // hand-computed first window of a row: after pixel (2,2) and after (3,2)
  logic [71:0] win_22 = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
  logic [71:0] win_32 = {8'd86, 8'd85, 8'd84, 8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'((r*W + c) & 255);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int idx);
    logic [WW-1:0] w;
    int r, c;
    r = (K-1) + idx / (W-K+1);
    c = (K-1) + idx % (W-K+1);
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = pix(r-K+1+i, c-K+1+j);
    return w;
  endfunction

  // observe outputs mid-cycle, then advance one clock
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc && cur_n == 2*W+2 && acc_cyc < 0) acc_cyc = cyc;
    if (out_valid && !ov_prev && ov_cyc < 0) ov_cyc = cyc;
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_win", out_win, prev_win);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
    if (out_valid && out_ready) begin
      chk("win", out_win, exp_win(exp_idx));
      if (exp_idx == 0)     chk("win_first", out_win, win_22);
      if (exp_idx == W-K+1) chk("win_row3",  out_win, win_32);
      exp_idx++;
      win_cnt++;
    end
    if (frame_done) done_cnt++;
    hold_prev = out_valid && !out_ready;
    prev_win  = out_win;
    ov_prev   = out_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input bit rnd, input int abort_at, input bit mid_start);
    int n, g;
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    exp_idx   = 0;
    win_cnt   = 0;
    done_cnt  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    rnd_rdy = rnd;
    chk("busy_after_start", busy, 1'b1);
    chk("err_after_start", err, 1'b0);
    n = 0;
    g = 0;
    while (n < NPIX && g < 20000) begin
      if (n == abort_at) begin
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        hold_prev = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_win", out_win, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        repeat (2) step();
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        return;
      end
      in_valid = 1'b1;
      in_data  = pix(n / W, n % W);
      cur_n    = n;
      start    = mid_start && (n == 400);
      step();
      if (acc) n++;
      g++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    cur_n    = -1;
    chk("feed_timeout", n, NPIX);
    g = 0;
    while (done_cnt == 0 && g < 500) begin
      step();
      g++;
    end
    repeat (3) step();
    chk("done_pulses", done_cnt, 1);
    chk("win_count", win_cnt, NWIN);
    chk("idle_busy", busy, 1'b0);
    chk("idle_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_win", out_win, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    step();

    // steady consumer: latency and full count
    run_frame(1'b0, -1, 1'b0);
    chk("latency", ov_cyc - acc_cyc, 2);

    // random backpressure
    run_frame(1'b1, -1, 1'b0);

    // start pulsed mid-frame is ignored
    run_frame(1'b1, -1, 1'b1);
    chk("err_mid_start", err, ERR_ON);

    // reset at pixel 300, then a clean frame
    run_frame(1'b0, 300, 1'b0);
    chk("err_after_reset", err, 1'b0);
    run_frame(1'b1, -1, 1'b0);

    // pixels offered in IDLE are refused
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    win_cnt   = 0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("idle_no_windows", win_cnt, 0);
    chk("idle_state", busy, 1'b0);
    chk("err_idle_pixel", err, ERR_ON);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gray_window_ctrl.md
Name: gray_window_ctrl

Overview:
Sliding-window controller for the grayscale conv input path. It accepts a raster pixel stream, sequences KSIZE-1 internal line RAMs with the same semantics as the gray line buffer (one write port, registered read with 1-cycle latency, depth IMG_IN_WIDTH), and emits one KSIZE x KSIZE window per valid output position. It sits between the pixel source and the conv MAC array, with valid/ready handshakes on both sides.

Parameters:
IMG_IN_WIDTH, 28, pixels per line; also the line RAM depth; must be >= KSIZE.
IMG_IN_HEIGHT, 28, lines per frame; must be >= KSIZE.
KSIZE, 3, window edge length; must be >= 2.

Ports:
clk  in  1  single clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that arms a frame; ignored unless state is IDLE.
in_valid  in  1  pixel valid.
in_ready  out  1  pixel accepted when in_valid && in_ready.
in_data  in  `CNN_DATA_IN_W  pixel, raster order.
out_valid  out  1  window valid.
out_ready  in  1  consumer ready.
out_win  out  KSIZE*KSIZE*`CNN_DATA_IN_W  flattened window.
busy  out  1  high in ACTIVE or DRAIN.
frame_done  out  1  one-cycle pulse when the last window of the frame is handed off.
err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset: state=IDLE; col, row, and pipeline valids =0; out_valid=0; out_win=0; busy=0; frame_done=0; err=0. Line RAM contents are not reset. Reset mid-frame aborts the frame; no partial windows are emitted after reset release.
- FSM: IDLE -(start)-> ACTIVE -(last pixel accepted: row=H-1, col=W-1)-> DRAIN -(pipeline empty and last window handed off)-> IDLE, with a frame_done pulse on that transition.
- in_ready = (state==ACTIVE) && !stall, where stall = out_valid && !out_ready. in_ready is 0 in IDLE and DRAIN.
- Counters: col increments per accepted pixel and wraps W-1->0, which increments row. Both counters clear on start.
- Pipeline stage 1 (accept cycle): latch the pixel, col and row; issue reads of all line RAMs at address col.
- Pipeline stage 2 (next cycle, RAM data returns): write back the shifted column, with lb[0][col]<=pixel and lb[k][col]<=old lb[k-1][col]. Shift the column (oldest row first, current pixel last) into a KSIZE-column window shift register.
- Stall behaviour: all pipeline registers hold while stall=1. RAM read and write of the same column never collide because consecutive accepted pixels have distinct columns (W >= 2).
- Output register: loads when stage 2 holds a pixel with row >= KSIZE-1 and col >= KSIZE-1, and the output slot is free or being drained that cycle. out_valid is held with stable out_win until out_ready is seen.
- Latency: pixel accepted at cycle t produces its window with out_valid=1 at t+2, given no stall.
- Window layout: out_win[(i*KSIZE+j)*`CNN_DATA_IN_W +: `CNN_DATA_IN_W] = pixel(row-KSIZE+1+i, col-KSIZE+1+j). i=0 is the oldest row and j=0 the leftmost column.
- Windows per frame: (H-KSIZE+1)*(W-KSIZE+1). Windows never straddle a line wrap: columns 0..KSIZE-2 of each row only prime the shift register.
- Simultaneous events: start during ACTIVE or DRAIN is ignored. out_ready without out_valid has no effect. A handoff and a new load in the same cycle are allowed (full throughput of 1 window per clock).

Optional Feature:
Macro `CNN_LB_ERR_FLAG_EN.
- Defined: err sets when in_valid=1 while state is IDLE or DRAIN (pixel outside a frame), or when start=1 while state is ACTIVE or DRAIN. err is sticky and clears only on an accepted start in IDLE, or on reset.
- Not defined: err is tied 0 and no detection logic is generated. All other behaviour is identical in both builds.

Test Plan:
- Default params, start, 784 pixels with value (r*28+c)&0xFF, out_ready=1 -> exactly 676 windows. The first window (after pixel (2,2)) is {0,1,2,28,29,30,56,57,58}, and out_valid rises 2 cycles after that pixel is accepted. frame_done pulses once, then state is IDLE.
- Same frame, out_ready toggled with a random 50% duty -> same 676 windows in order. out_win is stable while out_valid && !out_ready, and in_ready=0 during every stall.
- Check row edges -> no window is emitted for pixels with col<2 or row<2. The window after pixel (3,2) is {28,29,30,56,57,58,84,85,86}.
- rst_n asserted at pixel 300, then released, then a new start and full frame -> out_valid=0 immediately on reset. The new frame yields 676 correct windows with no stale data.
- start pulsed mid-frame -> ignored, frame completes normally. With `CNN_LB_ERR_FLAG_EN, err=1 and stays high until the next accepted start.
- in_valid=1 in IDLE with no start -> in_ready=0 and no windows. With the macro, err=1; without it, err=0.
